wb_bypass_buffer: RTL and testbench

//  Parametrised operand-forwarding unit for the pipelined MIPS core.
//  It merges the W-stage result select (ALU/DM/PC8) and keeps a shift-history of the last DEPTH retired register writes.
//  It supplies NRD read ports with the freshest value for each requested register, and raises a stall when an M-stage load result is needed and not yet available.
//  It sits between the regfile/pipeline registers and the consumers (M-stage store data, E-stage operands).

---
 rtl/wb_bypass_buffer_if.sv | 35 +++
 rtl/wb_bypass_buffer.sv | 133 +++++++++++++
 tb/tb_wb_bypass_buffer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/wb_bypass_buffer_if.sv
// Bundle of the W/M-stage write-back signals and operand read ports seen by wb_bypass_buffer.
// The consumer side of the pipeline drives through master; the forwarding unit takes slave.
interface wb_bypass_buffer_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int CNTW = 16
);
  logic              stall_in;
  logic [1:0]        res_w;
  logic [AW-1:0]     a3_w;
  logic [DW-1:0]     ao_w;
  logic [DW-1:0]     dr_w;
  logic [DW-1:0]     pc8_w;
  logic [1:0]        res_m;
  logic [AW-1:0]     a3_m;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_raw;
  logic [NRD-1:0]    rd_used;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD*2-1:0]  rd_src;
  logic              stall_req;
  logic [CNTW-1:0]   hit_w_cnt;
  logic [CNTW-1:0]   hit_h_cnt;

  modport master (
    output stall_in, res_w, a3_w, ao_w, dr_w, pc8_w, res_m, a3_m, rd_addr, rd_raw, rd_used,
    input  rd_data, rd_src, stall_req, hit_w_cnt, hit_h_cnt
  );

  modport slave (
    input  stall_in, res_w, a3_w, ao_w, dr_w, pc8_w, res_m, a3_m, rd_addr, rd_raw, rd_used,
    output rd_data, rd_src, stall_req, hit_w_cnt, hit_h_cnt
  );
endinterface

// File: rtl/wb_bypass_buffer.sv
// Operand forwarding for the pipelined MIPS core: W-stage bypass, a short history of retired
// writes, a load-use stall request and saturating forward-hit counters.
module wb_bypass_buffer #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int NRD   = 2,
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                reset,
  wb_bypass_buffer_if.slave   bus
);
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ALU  = 2'b01;
  localparam logic [1:0] RES_DM   = 2'b10;
  localparam logic [1:0] RES_PC8  = 2'b11;
  localparam logic [1:0] SRC_RAW  = 2'b00;
  localparam logic [1:0] SRC_W    = 2'b01;
  localparam logic [1:0] SRC_H    = 2'b10;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic en);
    if (en && (v != {CNTW{1'b1}})) return v + {{(CNTW-1){1'b0}}, 1'b1};
    return v;
  endfunction

  logic [DW-1:0]     wd_w;
  logic              w_wr;
  logic              vld_q  [DEPTH];
  logic              vld_d  [DEPTH];
  logic [AW-1:0]     addr_q [DEPTH];
  logic [AW-1:0]     addr_d [DEPTH];
  logic [DW-1:0]     data_q [DEPTH];
  logic [DW-1:0]     data_d [DEPTH];
  logic [CNTW-1:0]   hit_w_cnt_q, hit_w_cnt_d;
  logic [CNTW-1:0]   hit_h_cnt_q, hit_h_cnt_d;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD*2-1:0]  rd_src;
  logic              stall_req;
  logic              any_w;
  logic              any_h;

  always_comb begin
    case (bus.res_w)
      RES_ALU: wd_w = bus.ao_w;
      RES_DM:  wd_w = bus.dr_w;
      RES_PC8: wd_w = bus.pc8_w;
      default: wd_w = '0;
    endcase
    w_wr = (bus.res_w != RES_NONE) && (bus.a3_w != '0);
  end

  // Forward select: W first, then history scanned oldest-to-newest so the newest match wins.
  always_comb begin
    rd_data   = '0;
    rd_src    = '0;
    stall_req = 1'b0;
    any_w     = 1'b0;
    any_h     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*DW +: DW] = bus.rd_raw[i*DW +: DW];
      rd_src[i*2 +: 2]    = SRC_RAW;
      if (bus.rd_addr[i*AW +: AW] != '0) begin
        if (w_wr && (bus.a3_w == bus.rd_addr[i*AW +: AW])) begin
          rd_data[i*DW +: DW] = wd_w;
          rd_src[i*2 +: 2]    = SRC_W;
        end else begin
          for (int k = DEPTH - 1; k >= 0; k--) begin
            if (vld_q[k] && (addr_q[k] == bus.rd_addr[i*AW +: AW])) begin
              rd_data[i*DW +: DW] = data_q[k];
              rd_src[i*2 +: 2]    = SRC_H;
            end
          end
        end
      end
      if (bus.rd_used[i]) begin
        any_w = any_w | (rd_src[i*2 +: 2] == SRC_W);
        any_h = any_h | (rd_src[i*2 +: 2] == SRC_H);
        if ((bus.res_m == RES_DM) && (bus.a3_m == bus.rd_addr[i*AW +: AW]) && (bus.a3_m != '0))
          stall_req = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k];
      addr_d[k] = addr_q[k];
      data_d[k] = data_q[k];
    end
    hit_w_cnt_d = hit_w_cnt_q;
    hit_h_cnt_d = hit_h_cnt_q;
    if (!bus.stall_in) begin
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        addr_d[k] = addr_q[k-1];
        data_d[k] = data_q[k-1];
      end
      vld_d[0]    = w_wr;
      addr_d[0]   = bus.a3_w;
      data_d[0]   = wd_w;
      hit_w_cnt_d = sat_inc(hit_w_cnt_q, any_w);
      hit_h_cnt_d = sat_inc(hit_h_cnt_q, any_h);
    end
  end

  // History and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_q[k]  <= 1'b0;
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
      hit_w_cnt_q <= '0;
      hit_h_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_q[k]  <= vld_d[k];
        addr_q[k] <= addr_d[k];
        data_q[k] <= data_d[k];
      end
      hit_w_cnt_q <= hit_w_cnt_d;
      hit_h_cnt_q <= hit_h_cnt_d;
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.rd_src    = rd_src;
  assign bus.stall_req = stall_req;
  assign bus.hit_w_cnt = hit_w_cnt_q;
  assign bus.hit_h_cnt = hit_h_cnt_q;
endmodule

// File: tb/tb_wb_bypass_buffer.sv
// Directed bench for wb_bypass_buffer: W/history forwarding, priority, $0, load-use stall,
// stall hold, reset mid-stall and counter saturation (4-bit counters).
module tb_wb_bypass_buffer;
  localparam int DW = 32, AW = 5, DEPTH = 2, NRD = 2, CNTW = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  wb_bypass_buffer_if #(.DW(DW), .AW(AW), .NRD(NRD), .CNTW(CNTW)) bus ();

  wb_bypass_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [1:0] src(input int p);
    return bus.rd_src[p*2 +: 2];
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.stall_in = 0; bus.res_w = 0; bus.a3_w = 0; bus.ao_w = 0; bus.dr_w = 0; bus.pc8_w = 0;
    bus.res_m = 0; bus.a3_m = 0; bus.rd_addr = '0; bus.rd_used = '0;
    bus.rd_raw = {32'hCAFE_0001, 32'hDEAD_0000};
    tick();
    reset = 1'b0;

    // reset state
    bus.rd_addr[0 +: AW] = 5'd8;
    #1;
    check("rst_data0", dat(0), 32'hDEAD_0000);
    check("rst_src0", src(0), 2'b00);
    check("rst_hitw", bus.hit_w_cnt, 0);
    check("rst_hith", bus.hit_h_cnt, 0);

    // W forward and hit counter
    bus.res_w = 2'b01; bus.a3_w = 5'd8; bus.ao_w = 32'h1234; bus.rd_used = 2'b01;
    #1;
    check("w_data0", dat(0), 32'h1234);
    check("w_src0", src(0), 2'b01);
    tick();
    check("w_hitw", bus.hit_w_cnt, 1);
    check("w_hith", bus.hit_h_cnt, 0);

    // history lifetime: DM write of $9 visible for DEPTH cycles after W
    bus.res_w = 2'b10; bus.a3_w = 5'd9; bus.dr_w = 32'hA5; bus.ao_w = 32'h77;
    bus.rd_addr[0 +: AW] = 5'd9; bus.rd_used = 2'b00;
    tick();
    bus.res_w = 2'b00; bus.rd_used = 2'b01;
    #1;
    check("h1_data0", dat(0), 32'hA5);
    check("h1_src0", src(0), 2'b10);
    tick();
    check("h2_data0", dat(0), 32'hA5);
    check("h2_src0", src(0), 2'b10);
    tick();
    check("h3_data0", dat(0), 32'hDEAD_0000);
    check("h3_src0", src(0), 2'b00);
    check("h3_hith", bus.hit_h_cnt, 2);
    tick();
    check("h4_hith", bus.hit_h_cnt, 2);
    check("h4_hitw", bus.hit_w_cnt, 1);
    bus.rd_used = 2'b00;

    // priority: W over newer history over older history
    bus.res_w = 2'b01; bus.a3_w = 5'd9; bus.ao_w = 32'd1;
    tick();
    bus.ao_w = 32'd2;
    tick();
    bus.ao_w = 32'd3; bus.rd_addr[AW +: AW] = 5'd9;
    #1;
    check("pri_w_data0", dat(0), 32'd3);
    check("pri_w_src0", src(0), 2'b01);
    check("pri_w_data1", dat(1), 32'd3);
    bus.res_w = 2'b00;
    #1;
    check("pri_h_data0", dat(0), 32'd2);
    check("pri_h_src0", src(0), 2'b10);
    check("pri_h_data1", dat(1), 32'd2);

    // PC8 link to $31, and $0 never forwarded
    bus.res_w = 2'b11; bus.a3_w = 5'd31; bus.pc8_w = 32'h3008; bus.ao_w = 32'h1111; bus.dr_w = 32'h2222;
    bus.rd_addr[0 +: AW] = 5'd31;
    #1;
    check("pc8_data0", dat(0), 32'h3008);
    check("pc8_src0", src(0), 2'b01);
    bus.res_w = 2'b10; bus.a3_w = 5'd0; bus.rd_addr[0 +: AW] = 5'd0;
    #1;
    check("r0_data0", dat(0), 32'hDEAD_0000);
    check("r0_src0", src(0), 2'b00);
    bus.res_w = 2'b00;

    // load-use stall request
    bus.res_m = 2'b10; bus.a3_m = 5'd5; bus.rd_addr[AW +: AW] = 5'd5; bus.rd_used = 2'b10;
    #1;
    check("lu_stall", bus.stall_req, 1'b1);
    bus.rd_used = 2'b00;
    #1;
    check("lu_unused", bus.stall_req, 1'b0);
    bus.rd_used = 2'b10; bus.res_m = 2'b01;
    #1;
    check("lu_alu", bus.stall_req, 1'b0);
    bus.res_m = 2'b10; bus.a3_m = 5'd0; bus.rd_addr[AW +: AW] = 5'd0;
    #1;
    check("lu_r0", bus.stall_req, 1'b0);
    bus.res_m = 2'b00; bus.rd_used = 2'b00;

    // stall_in freezes history and counters
    bus.res_w = 2'b01; bus.a3_w = 5'd12; bus.ao_w = 32'hBEEF;
    tick();
    bus.stall_in = 1'b1; bus.a3_w = 5'd13; bus.ao_w = 32'h1111;
    bus.rd_addr[0 +: AW] = 5'd12; bus.rd_addr[AW +: AW] = 5'd13; bus.rd_used = 2'b01;
    tick(); tick(); tick();
    bus.res_w = 2'b00;
    #1;
    check("stl_data0", dat(0), 32'hBEEF);
    check("stl_src0", src(0), 2'b10);
    check("stl_data1", dat(1), 32'hCAFE_0001);
    check("stl_src1", src(1), 2'b00);
    check("stl_hitw", bus.hit_w_cnt, 1);
    check("stl_hith", bus.hit_h_cnt, 2);
    bus.stall_in = 1'b0;
    tick();
    check("unstl_hith", bus.hit_h_cnt, 3);

    // reset during stall clears history; W bypass still live
    bus.stall_in = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst2_data0", dat(0), 32'hDEAD_0000);
    check("rst2_src0", src(0), 2'b00);
    check("rst2_hitw", bus.hit_w_cnt, 0);
    check("rst2_hith", bus.hit_h_cnt, 0);
    bus.res_w = 2'b01; bus.a3_w = 5'd12; bus.ao_w = 32'h55;
    #1;
    check("rst2_wfwd", dat(0), 32'h55);

    // counter saturation at all-ones
    bus.stall_in = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    check("sat_hitw", bus.hit_w_cnt, 4'hF);
    check("sat_hith", bus.hit_h_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
